// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, external-data and ALU control bundle for alu_sequencer.
// master = sequencer side, slave = requester / ALU / data-stream side.
interface alu_sequencer_if #(
  parameter int OP_BITS = 3,
  parameter int BEAT_W  = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [OP_BITS-1:0] req_op;
  logic               req_pair;
  logic               req_ext;
  logic               req_mul;
  logic               data_valid;
  logic [OP_BITS-1:0] alu_op;
  logic               alu_pair_op;
  logic               alu_external_arg2;
  logic               alu_advance;
  logic               alu_regfile_en;
  logic               alu_op_done;
  logic               alu_do_mul;
  logic               alu_continue_mul;
  logic               busy;
  logic               done;
  logic               seq_err;
  logic [BEAT_W-1:0]  beat;

  modport master (
    input  req_valid, req_op, req_pair, req_ext, req_mul, data_valid, alu_op_done,
    output req_ready, alu_op, alu_pair_op, alu_external_arg2, alu_advance,
           alu_regfile_en, alu_do_mul, alu_continue_mul, busy, done, seq_err, beat
  );

  modport slave (
    output req_valid, req_op, req_pair, req_ext, req_mul, data_valid, alu_op_done,
    input  req_ready, alu_op, alu_pair_op, alu_external_arg2, alu_advance,
           alu_regfile_en, alu_do_mul, alu_continue_mul, busy, done, seq_err, beat
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps a serial ALU through the beats of a single (REG_BITS) or
// pair (2*REG_BITS) operation, NSHIFT bits per beat, stalling on the external
// data stream and cross-checking the ALU's last-beat flag against its own count.
// Optional feature macro ALU_SEQ_MUL_EN: enables the two-pass multiply sequence
// (RUN then MUL2). Without it, req_mul is ignored and multiplier controls are 0.
module alu_sequencer #(
  parameter int NSHIFT   = 2,
  parameter int REG_BITS = 8,
  parameter int OP_BITS  = 3
) (
  input logic              clk,
  input logic              reset,
  alu_sequencer_if.master  bus
);
  localparam int BEAT_W = $clog2(2*REG_BITS/NSHIFT);
  localparam logic [BEAT_W-1:0] LAST_SINGLE = BEAT_W'(REG_BITS/NSHIFT - 1);
  localparam logic [BEAT_W-1:0] LAST_PAIR   = BEAT_W'(2*REG_BITS/NSHIFT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_MUL2 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [OP_BITS-1:0] op_q, op_d;
  logic               pair_q, pair_d;
  logic               ext_q, ext_d;
  logic               mul_q, mul_d;
  logic               err_q, err_d;

  logic               active;
  logic               advance;
  logic               at_last;
  logic [BEAT_W-1:0]  last_beat;
  logic               mul_req;

`ifdef ALU_SEQ_MUL_EN
  assign mul_req = bus.req_mul;
`else
  logic unused_req_mul;
  assign unused_req_mul = bus.req_mul;
  assign mul_req        = 1'b0;
`endif

  // Beat stepping: advance while running unless waiting on external data.
  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_MUL2);
    advance   = active && (!ext_q || bus.data_valid);
    last_beat = (pair_q && !mul_q) ? LAST_PAIR : LAST_SINGLE;
    at_last   = (beat_q == last_beat);
  end

  // Next-state logic: accept in IDLE, count beats, flag ALU/beat disagreement.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    op_d    = op_q;
    pair_d  = pair_q;
    ext_d   = ext_q;
    mul_d   = mul_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_RUN;
          beat_d  = '0;
          op_d    = bus.req_op;
          pair_d  = bus.req_pair;
          ext_d   = bus.req_ext;
          mul_d   = mul_req;
        end
      end
      S_RUN, S_MUL2: begin
        if (advance) begin
          // The ALU's done flag must coincide exactly with our last beat.
          if (bus.alu_op_done != at_last) begin
            err_d = 1'b1;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (at_last) begin
            if ((state_q == S_RUN) && mul_q) begin
              state_d = S_MUL2;
              beat_d  = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything, including mid-operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      op_q    <= '0;
      pair_q  <= 1'b0;
      ext_q   <= 1'b0;
      mul_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      pair_q  <= pair_d;
      ext_q   <= ext_d;
      mul_q   <= mul_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready         = (state_q == S_IDLE);
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.done              = (state_q == S_DONE);
  assign bus.seq_err           = err_q;
  assign bus.beat              = beat_q;
  assign bus.alu_op            = op_q;
  assign bus.alu_pair_op       = pair_q;
  assign bus.alu_external_arg2 = ext_q;
  assign bus.alu_advance       = advance;
  assign bus.alu_regfile_en    = advance;

`ifdef ALU_SEQ_MUL_EN
  assign bus.alu_do_mul       = mul_q && active;
  assign bus.alu_continue_mul = (state_q == S_MUL2);
`else
  assign bus.alu_do_mul       = 1'b0;
  assign bus.alu_continue_mul = 1'b0;
`endif
endmodule
